// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: two-entry skid buffer that registers {pc, instruction} from fetch and presents them to decode.
module fetch_decode_buffer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
  parameter int PERF_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_pc_plus4,
  output logic [XLEN-1:0]       out_instruction,
  output logic [PERF_WIDTH-1:0] stall_cycles
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0] state;
  logic [XLEN-1:0] head_pc, head_instruction, skid_pc, skid_instruction;
  logic push, pop;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_pc = head_pc;
  assign out_pc_plus4 = head_pc + XLEN'(4);
  assign out_instruction = out_valid ? head_instruction : NOP_INSTR;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= EMPTY;
      head_pc <= '0;
      head_instruction <= NOP_INSTR;
      skid_pc <= '0;
      skid_instruction <= NOP_INSTR;
      stall_cycles <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (flush) state <= EMPTY;
      else if (state == FULL) begin
        if (pop) begin
          state <= ONE;
          head_pc <= skid_pc;
          head_instruction <= skid_instruction;
        end
      end else if (push) begin
        // an empty buffer, or a head leaving this cycle, lets the new word become head directly
        if (state == EMPTY || pop) begin
          state <= ONE;
          head_pc <= in_pc;
          head_instruction <= in_instruction;
        end else begin
          state <= FULL;
          skid_pc <= in_pc;
          skid_instruction <= in_instruction;
        end
      end else if (pop) state <= EMPTY;
    end
  end
endmodule
